// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command buffer.
//   ALU_W     : datapath width of the attached combinational ALU
//   OP_*      : ALU opcodes as driven on alu_sel
//   alu_cmd_t : one buffered command {sel, a, b, acc}
package alu_pkg;
  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [2:0]       sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic             acc;
  } alu_cmd_t;

  // Carry/overflow are only meaningful for add and subtract.
  function automatic logic has_arith_flags(input logic [2:0] sel);
    return (sel == OP_ADD) || (sel == OP_SUB);
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding alu_cmd_t entries.
//   clk, rst_n         : clock, async active-low reset
//   i_push, i_data     : write request and payload (ignored when full)
//   i_pop              : read request (ignored when empty)
//   o_head             : entry at the read pointer
//   o_full, o_empty    : occupancy status
//   o_count            : occupancy, 0..DEPTH
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  alu_cmd_t      i_data,
  input  logic          i_pop,
  output alu_cmd_t      o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  alu_cmd_t      r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// Command buffer and result stage around an external combinational ALU.
//   cmd_valid/cmd_ready/cmd_*  : command input (sel, a, b, use-accumulator)
//   acc_clr                    : synchronous accumulator clear
//   alu_a/alu_b/alu_sel        : head command driven to the ALU (0 when empty)
//   alu_out/alu_cf/of/zf       : ALU result returned combinationally
//   res_valid/res_ready/res_*  : registered result with valid/ready handshake
//   acc                        : accumulator (last captured result)
//   count                      : FIFO occupancy
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ALU_W,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_sel,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  input  logic          cmd_acc,
  input  logic          acc_clr,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    alu_sel,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_cf,
  input  logic          alu_of,
  input  logic          alu_zf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic          res_cf,
  output logic          res_of,
  output logic          res_zf,
  output logic [W-1:0]  acc,
  output logic [CW-1:0] count
);
  alu_cmd_t     w_cmd, w_head;
  logic         w_full, w_empty, w_cap;
  logic         r_res_valid, r_res_cf, r_res_of, r_res_zf;
  logic [W-1:0] r_res_data, r_acc;

  assign w_cmd = '{sel: cmd_sel, a: cmd_a, b: cmd_b, acc: cmd_acc};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cmd_valid),
    .i_data  (w_cmd),
    .i_pop   (w_cap),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign cmd_ready = !w_full;

  // The accumulator operand reads the registered acc, so a chained command
  // right behind its producer sees the freshly captured value with no bubble.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!w_empty) begin
      alu_sel = w_head.sel;
      alu_b   = w_head.b;
      alu_a   = w_head.acc ? r_acc : w_head.a;
    end
  end

  assign w_cap = !w_empty && (!r_res_valid || res_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cf    <= 1'b0;
      r_res_of    <= 1'b0;
      r_res_zf    <= 1'b0;
    end else if (w_cap) begin
      r_res_valid <= 1'b1;
      r_res_data  <= alu_out;
      r_res_zf    <= alu_zf;
      r_res_cf    <= alu_cf && has_arith_flags(alu_sel);
      r_res_of    <= alu_of && has_arith_flags(alu_sel);
    end else if (res_ready) begin
      r_res_valid <= 1'b0;  // drain only; data/flags hold
    end
  end

  // Clear wins over a same-cycle capture for the accumulator only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (acc_clr) r_acc <= '0;
    else if (w_cap)   r_acc <= alu_out;
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_cf    = r_res_cf;
  assign res_of    = r_res_of;
  assign res_zf    = r_res_zf;
  assign acc       = r_acc;
endmodule
